// File: rtl/adaptive_binarize_pkg.sv
// rtl/adaptive_binarize_pkg.sv - shared helpers, derived widths and FSM states for the streaming binarizer
package adaptive_binarize_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input longint v);
        int r;
        r = 0;
        for (int i = 0; i < 63; i++) begin
            if ((64'd1 << r) < v) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Window reach on each side of the centre pixel.
    function automatic int half_of(input int kernel);
        return (kernel - 1) / 2;
    endfunction

    // Width holding KERNEL*KERNEL full-scale pixels.
    function automatic int sum_w_of(input int pix_w, input int kernel);
        return pix_w + clog2(kernel * kernel);
    endfunction

    // Pixels that must be in before the first window is complete.
    function automatic int lag_of(input int img_w, input int kernel);
        return half_of(kernel) * img_w + half_of(kernel);
    endfunction

    // Covers both sum*100 and centre*KERNEL^2*percent (percent is 8 bits).
    function automatic int prod_w_of(input int pix_w, input int kernel);
        return pix_w + clog2(kernel * kernel) + 8;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_e;

endpackage

// File: rtl/adaptive_binarize_stream_line_buf.sv
// rtl/adaptive_binarize_stream_line_buf.sv - one-row pixel delay line (binarize_line_buf)
module binarize_line_buf
    import adaptive_binarize_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;

    // Oldest entry is read before it is overwritten, giving exactly DEPTH enables of delay.
    assign dout = r_mem[r_ptr];

    // Storage needs no reset: contents before a full row has passed are masked upstream.
    always_ff @(posedge clk) begin
        if (en) begin
            r_mem[r_ptr] <= din;
        end
    end

    // Circular write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (en) begin
            if (r_ptr == PTR_W'(DEPTH - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= r_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/adaptive_binarize_stream.sv
// rtl/adaptive_binarize_stream.sv - streaming KxK local-mean binarizer with zero-padded windows
module adaptive_binarize_stream
    import adaptive_binarize_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int KERNEL = 3,
    parameter int PIX_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       cfg_percent,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last
);

    localparam int HALF   = half_of(KERNEL);
    localparam int SUM_W  = sum_w_of(PIX_W, KERNEL);
    localparam int LAG    = lag_of(IMG_W, KERNEL);
    localparam int PROD_W = prod_w_of(PIX_W, KERNEL);
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int CNT_W  = clog2(NPIX + 1);
    localparam int ROW_W  = clog2(IMG_H + 1);
    localparam int COL_W  = clog2(IMG_W + 1);

    state_e            r_state;
    state_e            w_next_state;
    logic [CNT_W-1:0]  r_in_cnt;
    logic [ROW_W-1:0]  r_crow;
    logic [COL_W-1:0]  r_ccol;
    logic [7:0]        r_percent;
    logic              r_out_valid;
    logic              r_out_bit;
    logic              r_out_last;

    logic              w_slot_free;
    logic              w_adv;
    logic              w_emit;
    logic              w_in_ready;
    logic              w_is_last_pos;
    logic              w_dec;
    logic [PIX_W-1:0]  w_pix_in;
    logic [SUM_W-1:0]  w_sum;
    logic [PROD_W-1:0] w_lhs;
    logic [PROD_W-1:0] w_rhs;

    // Column 0 of the window is combinational (new pixel / line-buffer taps); older columns are stored.
    logic [PIX_W-1:0]  r_win  [KERNEL][KERNEL-1];
    logic [PIX_W-1:0]  w_nwin [KERNEL][KERNEL];
    logic [PIX_W-1:0]  w_lb_in  [KERNEL-1];
    logic [PIX_W-1:0]  w_lb_out [KERNEL-1];

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_bit   = r_out_bit;
    assign out_last  = r_out_last;

    // Flush shifts in a filler value; every tap it reaches lies outside the frame and is masked.
    assign w_pix_in      = (r_state == FLUSH) ? '0 : in_pixel;
    assign w_is_last_pos = (r_crow == ROW_W'(IMG_H - 1)) && (r_ccol == COL_W'(IMG_W - 1));

    // Line buffers chained so tap r holds the pixel r rows above the newest one.
    for (genvar g = 0; g < KERNEL - 1; g++) begin : g_lb
        if (g == 0) begin : g_first
            assign w_lb_in[g] = w_pix_in;
        end else begin : g_next
            assign w_lb_in[g] = w_lb_out[g-1];
        end
        binarize_line_buf #(
            .DEPTH (IMG_W),
            .WIDTH (PIX_W)
        ) u_line_buf (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (w_adv),
            .din   (w_lb_in[g]),
            .dout  (w_lb_out[g])
        );
    end

    // Window as it will look after this advance, so the decision can be registered in one cycle.
    for (genvar gr = 0; gr < KERNEL; gr++) begin : g_row
        for (genvar gk = 0; gk < KERNEL; gk++) begin : g_col
            if (gk == 0 && gr == 0) begin : g_new
                assign w_nwin[gr][gk] = w_pix_in;
            end else if (gk == 0) begin : g_lbtap
                assign w_nwin[gr][gk] = w_lb_out[gr-1];
            end else begin : g_shift
                assign w_nwin[gr][gk] = r_win[gr][gk-1];
            end
        end
    end

    // Window shift register advances with the stream.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int rr = 0; rr < KERNEL; rr++) begin
                for (int kk = 0; kk < KERNEL - 1; kk++) begin
                    r_win[rr][kk] <= w_nwin[rr][kk];
                end
            end
        end
    end

    // Masked window sum; masks come from the centre position so wrapped taps never leak in.
    always_comb begin
        int v_row;
        int v_col;
        w_sum = '0;
        for (int rr = 0; rr < KERNEL; rr++) begin
            for (int kk = 0; kk < KERNEL; kk++) begin
                v_row = int'(r_crow) + HALF - rr;
                v_col = int'(r_ccol) + HALF - kk;
                if (v_row >= 0 && v_row < IMG_H && v_col >= 0 && v_col < IMG_W) begin
                    w_sum = w_sum + SUM_W'(w_nwin[rr][kk]);
                end
            end
        end
    end

    // Full-precision compare of sum*100 against centre*KERNEL^2*percent.
    always_comb begin
        w_lhs = PROD_W'(w_sum) * PROD_W'(100);
        w_rhs = PROD_W'(w_nwin[HALF][HALF]) * PROD_W'(KERNEL * KERNEL) * PROD_W'(r_percent);
        w_dec = !(w_lhs > w_rhs);
    end

    // Next-state and handshake decode.
    always_comb begin
        w_next_state = r_state;
        w_slot_free  = !r_out_valid || out_ready;
        w_in_ready   = (r_state != FLUSH) && w_slot_free && rst_n;
        w_adv        = 1'b0;
        w_emit       = 1'b0;
        case (r_state)
            IDLE: begin
                w_adv = w_slot_free && in_valid;
                if (w_adv) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                w_adv = w_slot_free && in_valid;
                if (w_adv && r_in_cnt == CNT_W'(LAG - 1)) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_adv  = w_slot_free && in_valid;
                w_emit = w_adv;
                if (w_adv && r_in_cnt == CNT_W'(NPIX - 1)) begin
                    w_next_state = FLUSH;
                end
            end
            FLUSH: begin
                w_adv  = w_slot_free;
                w_emit = w_adv;
                if (w_adv && w_is_last_pos) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State, counters, latched percent and the registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_cnt    <= '0;
            r_crow      <= '0;
            r_ccol      <= '0;
            r_percent   <= '0;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_adv && r_state == IDLE) begin
                r_in_cnt  <= CNT_W'(1);
                r_percent <= cfg_percent;
            end else if (w_adv && r_state != FLUSH) begin
                r_in_cnt <= r_in_cnt + CNT_W'(1);
            end
            if (w_emit) begin
                if (r_ccol == COL_W'(IMG_W - 1)) begin
                    r_ccol <= '0;
                    r_crow <= w_is_last_pos ? '0 : r_crow + ROW_W'(1);
                end else begin
                    r_ccol <= r_ccol + COL_W'(1);
                end
                r_out_valid <= 1'b1;
                r_out_bit   <= w_dec;
                r_out_last  <= w_is_last_pos;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adaptive_binarize_stream.sv
// tb/tb_adaptive_binarize_stream.sv - randomized self-checking bench against a window-sum reference
module tb_adaptive_binarize_stream;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int K  = 3;
    localparam int N  = W * H;
    localparam int HF = (K - 1) / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cfg_percent = 8'd110;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_pixel = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_bit;
    logic       out_last;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] img [N];
    logic       exp_q [N];

    adaptive_binarize_stream #(
        .IMG_W  (W),
        .IMG_H  (H),
        .KERNEL (K),
        .PIX_W  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_percent (cfg_percent),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pixel    (in_pixel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bit     (out_bit),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: zero-padded neighbourhood sum straight from the image array.
    function automatic logic golden_bit(input int r, input int c, input int pct);
        longint s;
        longint ctr;
        s = 0;
        for (int dr = -HF; dr <= HF; dr++) begin
            for (int dc = -HF; dc <= HF; dc++) begin
                if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W) begin
                    s += longint'(img[(r + dr) * W + (c + dc)]);
                end
            end
        end
        ctr = longint'(img[r * W + c]);
        return (s * 100 > ctr * K * K * pct) ? 1'b0 : 1'b1;
    endfunction

    task automatic send_pixel(input logic [7:0] v, input string tag);
        int   t;
        logic acc;
        t   = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_pixel = v;
        while (!acc && t < 1000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        check_eq({tag, " accept"}, 32'(acc), 32'd1);
    endtask

    // ready_mode: 0 always ready, 1 toggling 1010, 2 random.
    task automatic run_frame(input string name, input int ready_mode, input int gap_max,
                             input int pct_first, input int pct_mid);
        cfg_percent = 8'(pct_first);
        for (int i = 0; i < N; i++) begin
            exp_q[i] = golden_bit(i / W, i % W, pct_first);
        end
        fork
            begin : drv
                for (int p = 0; p < N; p++) begin
                    if (gap_max > 0) begin
                        repeat ($urandom_range(0, gap_max)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                    send_pixel(img[p], name);
                    if (p == 0) begin
                        cfg_percent = 8'(pct_mid);
                    end
                end
            end
            begin : mon
                int   got;
                int   cyc;
                logic pv;
                logic pb;
                logic pl;
                got = 0;
                cyc = 0;
                pv  = 1'b0;
                pb  = 1'b0;
                pl  = 1'b0;
                while (got < N && cyc < 3000) begin
                    case (ready_mode)
                        0:       out_ready = 1'b1;
                        1:       out_ready = (cyc % 2 == 0);
                        default: out_ready = 1'($urandom_range(0, 1));
                    endcase
                    @(negedge clk);
                    if (pv) begin
                        check_eq({name, " stall valid"}, 32'(out_valid), 32'd1);
                        check_eq({name, " stall bit"}, 32'(out_bit), 32'(pb));
                        check_eq({name, " stall last"}, 32'(out_last), 32'(pl));
                    end
                    if (out_valid && out_ready) begin
                        check_eq($sformatf("%s bit[%0d]", name, got), 32'(out_bit), 32'(exp_q[got]));
                        check_eq($sformatf("%s last[%0d]", name, got), 32'(out_last), 32'(got == N - 1));
                        got++;
                    end
                    pv = out_valid && !out_ready;
                    pb = out_bit;
                    pl = out_last;
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                check_eq({name, " count"}, 32'(got), 32'(N));
                out_ready = 1'b1;
                @(negedge clk);
                check_eq({name, " no extra"}, 32'(out_valid), 32'd0);
                @(posedge clk);
                #1;
            end
        join
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < N; i++) begin
            img[i] = v;
        end
    endtask

    initial begin
        #12;
        check_eq("reset out_valid", 32'(out_valid), 32'd0);
        check_eq("reset out_bit", 32'(out_bit), 32'd0);
        check_eq("reset out_last", 32'(out_last), 32'd0);
        check_eq("reset in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fill_const(8'd50);
        run_frame("uniform50", 0, 0, 110, 110);

        fill_const(8'd200);
        img[1 * W + 1] = 8'd10;
        run_frame("spot", 0, 0, 110, 110);

        fill_const(8'd0);
        run_frame("zeros", 0, 0, 110, 110);

        fill_const(8'd255);
        img[0] = 8'd0;
        run_frame("dark corner", 0, 0, 110, 110);

        fill_const(8'd200);
        img[1 * W + 1] = 8'd10;
        run_frame("spot stalled", 1, 3, 110, 110);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) begin
                img[i] = 8'($urandom_range(0, 255));
            end
            run_frame($sformatf("random%0d", f), 2, 2, int'($urandom_range(50, 150)), 110);
        end

        fill_const(8'd50);
        run_frame("pct midframe", 0, 0, 110, 50);
        run_frame("pct next", 0, 0, 50, 50);

        out_ready   = 1'b1;
        cfg_percent = 8'd110;
        for (int p = 0; p < 7; p++) begin
            send_pixel(8'(p * 20), "partial");
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midreset out_valid", 32'(out_valid), 32'd0);
        check_eq("midreset in_ready", 32'(in_ready), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check_eq("midreset hold valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill_const(8'd50);
        run_frame("after reset", 0, 0, 110, 110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adaptive_binarize_stream.md
Name: adaptive_binarize_stream

Overview:
- Streaming successor to the combinational 3x3 local-threshold binarizer.
- Accepts 8-bit grey pixels in raster order over a valid/ready handshake and buffers KERNEL-1 image rows.
- Forms a zero-padded KERNEL x KERNEL window sum around each pixel and emits one binary pixel per input pixel, in raster order: 0 = darker than the local mean scaled by percent (ink), 1 = background.
- Sits between the image-loader stream and the text-extraction/OCR stage; frame size is set at elaboration, threshold percent is runtime-configurable.

Parameters:
- IMG_W, 640, pixels per row (>= KERNEL).
- IMG_H, 480, rows per frame (>= KERNEL).
- KERNEL, 3, odd window size, legal 3..7; HALF = (KERNEL-1)/2.
- PIX_W, 8, input pixel width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_percent  in  8  threshold percent (e.g. 110); sampled on the first accepted pixel of each frame.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts in_pixel this cycle.
- in_pixel  in  PIX_W  grey value.
- out_valid  out  1  out_bit valid.
- out_ready  in  1  downstream accepts out_bit.
- out_bit  out  1  binarized pixel.
- out_last  out  1  high with the final pixel (row IMG_H-1, col IMG_W-1) of a frame.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_bit=0, out_last=0, in_ready=0, FSM=IDLE, all counters=0. Line-buffer contents are don't-care: padding is generated from position, never from stale data.
- Reset mid-frame: the partial frame is discarded with no outputs. The first pixel accepted after release is row 0, col 0 of a new frame.
- Handshake:
  - adv = (!out_valid | out_ready) & (FSM==FILL|RUN ? in_valid : FSM==FLUSH).
  - in_ready = (FSM != FLUSH) & (!out_valid | out_ready) & rst_n.
  - out_valid, out_bit and out_last hold stable while out_valid & !out_ready.
- FSM:
  - IDLE: in_ready=1; first accept latches cfg_percent -> FILL.
  - FILL: accepts pixels, no outputs, until HALF*IMG_W+HALF pixels are in (center lag) -> RUN.
  - RUN: each accept produces one output for center position (input index - lag). Accept of pixel IMG_W*IMG_H-1 -> FLUSH.
  - FLUSH: no input. The lag outputs are generated with zero padding for missing rows/cols, one per adv. The output carrying out_last -> IDLE.
- Frame boundary: a new frame's pixels are not accepted until FLUSH completes. in_ready=0 throughout FLUSH.
- Window: a tap at row<0, row>=IMG_H, col<0 or col>=IMG_W contributes 0. Row wrap must never leak previous-row pixels into column padding.
- Arithmetic:
  - SUM_W = PIX_W + clog2(KERNEL*KERNEL).
  - Decision, full precision, no truncation: out_bit = 0 iff sum*100 > center*KERNEL*KERNEL*percent, else 1.
  - Use MUL widths sized for the maximum operand values.
- Latency: out_valid rises 1 clk after the adv that completes a window (registered output). Throughput is 1 pixel/clk with no backpressure.
- Frame sequencing: exactly IMG_W*IMG_H outputs per frame, in raster order. Back-to-back frames are allowed after IDLE.

Decomposition:
- Package adaptive_binarize_pkg holds:
  - clog2 function;
  - localparams HALF, SUM_W, LAG = HALF*IMG_W+HALF, PROD_W;
  - FSM state enum IDLE/FILL/RUN/FLUSH.
- Sub-module binarize_line_buf: a single-row delay line of depth IMG_W x PIX_W with an enable. KERNEL-1 instances are chained; the top module keeps the KERNEL x KERNEL shift-register window, row/col counters, padding masks, adder tree and comparator.

Test Plan:
- IMG_W=IMG_H=4, KERNEL=3, percent=110, all pixels 50, out_ready=1 -> 16 outputs, all 1. Corner sum 200 -> 20000 <= 49500. Interior sum 450 -> 45000 <= 49500. out_last only on the 16th.
- Same frame, pixel (1,1)=10, others 200 -> out_bit(1,1)=0 (161000 > 9900). All others 1. Corner (0,0) sum=610 -> 61000 <= 198000.
- All pixels 0 -> every out_bit=1 (0 > 0 false). Zero pixels at (0,0) with neighbours 255 -> out_bit 0.
- Stream frame with out_ready toggling 1010... and random in_valid gaps -> output sequence identical to the no-stall run, no drops or duplicates, out_bit stable while stalled.
- cfg_percent changed from 110 to 50 mid-frame -> current frame still uses 110. The next frame uses 50: the uniform-50 frame interior gives 45000 > 22500 -> 0.
- Assert rst_n=0 after 7 pixels, release, send a full frame -> outputs out_valid=0 during reset, then exactly 16 outputs matching the golden frame.
